// File: rtl/clnx_spi_pkg.sv
// Shared constants, FSM state type and frame builder for the CTRL_SPI initiator.
package clnx_spi_pkg;

  localparam logic [7:0] OP_WR      = 8'h02;
  localparam logic [7:0] OP_RD      = 8'h03;
  localparam int         FRAME_BITS = 24;
  localparam int         BIT_W      = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } spi_state_e;

  // Read frames carry a zero data byte; the peripheral answers on MISO instead.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic       wr,
                                                        input logic [7:0] addr,
                                                        input logic [7:0] wdata);
    return {(wr ? OP_WR : OP_RD), addr, (wr ? wdata : 8'h00)};
  endfunction

endpackage

// File: rtl/clnx_spi_sck_gen.sv
// SCK phase generator: CLK_DIV-cycle low/high phases per bit, bit counter and
// fall/rise/late-sample strobes that are high in the cycle SCK shows the event.
module clnx_spi_sck_gen
  import clnx_spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic             i_clk,
  input  logic             i_srst,
  input  logic             i_start,
  output logic             o_sck,
  output logic             o_fall,
  output logic             o_rise,
  output logic             o_late,
  output logic             o_done,
  output logic [BIT_W-1:0] o_bit
);

  localparam int               CW       = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
  localparam logic [CW-1:0]    CNT_LOAD = CW'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(FRAME_BITS - 1);

  logic             run_q, run_d;
  logic             sck_q, sck_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      run_q <= 1'b0;
      sck_q <= 1'b1;
      cnt_q <= '0;
      bit_q <= BIT_TOP;
    end else begin
      run_q <= run_d;
      sck_q <= sck_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
    end
  end

  // The first fall keeps bit 23; every later fall moves to the next bit.
  always_comb begin
    run_d = run_q;
    sck_d = sck_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    if (i_start) begin
      run_d = 1'b1;
      sck_d = 1'b0;
      cnt_d = CNT_LOAD;
      bit_d = BIT_TOP;
    end else if (run_q) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end else if (!sck_q) begin
        sck_d = 1'b1;
        cnt_d = CNT_LOAD;
      end else if (bit_q == '0) begin
        run_d = 1'b0;
        bit_d = BIT_TOP;
      end else begin
        sck_d = 1'b0;
        cnt_d = CNT_LOAD;
        bit_d = bit_q - BIT_W'(1);
      end
    end
  end

  assign o_sck  = sck_q;
  assign o_bit  = bit_q;
  assign o_fall = run_q && !sck_q && (cnt_q == CNT_LOAD);
  assign o_rise = run_q &&  sck_q && (cnt_q == CNT_LOAD);
  assign o_late = run_q &&  sck_q && (cnt_q == '0);
  assign o_done = o_late && (bit_q == '0);

endmodule

// File: rtl/clnx_spi_ctrl_master.sv
// CTRL_SPI initiator: single-byte register read/write over a 24-bit mode-3 frame.
// Optional CLNX_SPI_LATE_SAMPLE_EN moves MISO sampling to the end of each SCK high phase.
//
// state    | meaning
// ST_IDLE  | ready for a request, CSN high
// ST_SETUP | CSN low, SCK high, bit 23 on MOSI for CS_SETUP cycles
// ST_SHIFT | 24 SCK periods, MOSI on falls, MISO sampled in high phase
// ST_HOLD  | CSN low, SCK high for CS_HOLD cycles
// ST_GAP   | CSN high for CS_HOLD cycles, response pulsed on entry
module clnx_spi_ctrl_master
  import clnx_spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic       i_clk,
  input  logic       i_srst,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic       i_req_wr,
  input  logic [7:0] i_req_addr,
  input  logic [7:0] i_req_wdata,
  output logic       o_rsp_valid,
  output logic [7:0] o_rsp_rdata,
  output logic       o_spi_csn,
  output logic       o_spi_sck,
  output logic       o_spi_mosi,
  input  logic       i_spi_miso
);

  localparam int               TMR_MAX    = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int               TW         = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX);
  localparam logic [TW-1:0]    SETUP_LOAD = TW'(CS_SETUP - 1);
  localparam logic [TW-1:0]    HOLD_LOAD  = TW'(CS_HOLD - 1);
  localparam logic [BIT_W-1:0] BIT_TOP    = BIT_W'(FRAME_BITS - 1);

  spi_state_e            state_q, state_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic                  wr_q, wr_d;
  logic [7:0]            rx_q, rx_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [7:0]            rdata_q, rdata_d;
  logic                  miso_s1_q, miso_s2_q;

  logic             start;
  logic             sck, fall, rise, late, done;
  logic [BIT_W-1:0] bit_idx;
  logic             shift_now;
  logic             sample;
  logic             unused_strobe;

  clnx_spi_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .i_clk   (i_clk),
    .i_srst  (i_srst),
    .i_start (start),
    .o_sck   (sck),
    .o_fall  (fall),
    .o_rise  (rise),
    .o_late  (late),
    .o_done  (done),
    .o_bit   (bit_idx)
  );

`ifdef CLNX_SPI_LATE_SAMPLE_EN
  assign sample        = late;
  assign unused_strobe = rise;
`else
  assign sample        = rise;
  assign unused_strobe = late;
`endif

  assign shift_now = fall && (bit_idx != BIT_TOP);

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      state_q     <= ST_IDLE;
      tmr_q       <= '0;
      frame_q     <= '0;
      wr_q        <= 1'b0;
      rx_q        <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      miso_s1_q   <= 1'b0;
      miso_s2_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      frame_q     <= frame_d;
      wr_q        <= wr_d;
      rx_q        <= rx_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      miso_s1_q   <= i_spi_miso;
      miso_s2_q   <= miso_s1_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    frame_d     = frame_q;
    wr_d        = wr_q;
    rx_d        = rx_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    start       = 1'b0;

    if (shift_now) frame_d = {frame_q[FRAME_BITS-2:0], 1'b0};
    if (sample)    rx_d    = {rx_q[6:0], miso_s2_q};

    unique case (state_q)
      ST_IDLE: begin
        if (i_req_valid) begin
          state_d = ST_SETUP;
          tmr_d   = SETUP_LOAD;
          frame_d = build_frame(i_req_wr, i_req_addr, i_req_wdata);
          wr_d    = i_req_wr;
          rx_d    = '0;
        end
      end
      ST_SETUP: begin
        if (tmr_q == '0) begin
          state_d = ST_SHIFT;
          start   = 1'b1;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      ST_SHIFT: begin
        if (done) begin
          state_d = ST_HOLD;
          tmr_d   = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if (tmr_q == '0) begin
          state_d     = ST_GAP;
          tmr_d       = HOLD_LOAD;
          rsp_valid_d = 1'b1;
          rdata_d     = wr_q ? 8'h00 : rx_q;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      ST_GAP: begin
        if (tmr_q == '0) state_d = ST_IDLE;
        else             tmr_d   = tmr_q - TW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // On a fall cycle the shift has not landed yet, so MOSI looks one bit ahead.
  always_comb begin
    o_spi_mosi = 1'b0;
    if (state_q == ST_SETUP) begin
      o_spi_mosi = frame_q[FRAME_BITS-1];
    end else if (state_q == ST_SHIFT) begin
      o_spi_mosi = shift_now ? frame_q[FRAME_BITS-2] : frame_q[FRAME_BITS-1];
    end
  end

  assign o_req_ready = (state_q == ST_IDLE) && !i_srst;
  assign o_spi_csn   = !((state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD));
  assign o_spi_sck   = sck;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rdata_q;

endmodule

// File: tb/tb_clnx_spi_ctrl_master.sv
// Directed bench for clnx_spi_ctrl_master: default-timing instance A and a
// fast-timing instance B (CLK_DIV=2, CS_SETUP=1, CS_HOLD=1), each with a MISO model.
module tb_clnx_spi_ctrl_master;

  localparam int CLK_DIV_A = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic       srst_a = 1'b1, valid_a = 1'b0, wr_a = 1'b0;
  logic [7:0] addr_a = 8'h00, wdata_a = 8'h00;
  logic       ready_a, rsp_a, csn_a, sck_a, mosi_a;
  logic [7:0] rdata_a;
  logic       miso_a = 1'b0;

  logic       srst_b = 1'b1, valid_b = 1'b0, wr_b = 1'b0;
  logic [7:0] addr_b = 8'h00, wdata_b = 8'h00;
  logic       ready_b, rsp_b, csn_b, sck_b, mosi_b;
  logic [7:0] rdata_b;
  logic       miso_b = 1'b0;

  clnx_spi_ctrl_master #(.CLK_DIV(CLK_DIV_A), .CS_SETUP(2), .CS_HOLD(2)) u_dut_a (
    .i_clk(clk), .i_srst(srst_a), .i_req_valid(valid_a), .o_req_ready(ready_a),
    .i_req_wr(wr_a), .i_req_addr(addr_a), .i_req_wdata(wdata_a),
    .o_rsp_valid(rsp_a), .o_rsp_rdata(rdata_a),
    .o_spi_csn(csn_a), .o_spi_sck(sck_a), .o_spi_mosi(mosi_a), .i_spi_miso(miso_a)
  );

  clnx_spi_ctrl_master #(.CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1)) u_dut_b (
    .i_clk(clk), .i_srst(srst_b), .i_req_valid(valid_b), .o_req_ready(ready_b),
    .i_req_wr(wr_b), .i_req_addr(addr_b), .i_req_wdata(wdata_b),
    .o_rsp_valid(rsp_b), .o_rsp_rdata(rdata_b),
    .o_spi_csn(csn_b), .o_spi_sck(sck_b), .o_spi_mosi(mosi_b), .i_spi_miso(miso_b)
  );

  // Peripheral model A: bits 7..0 of miso_byte_a during the data byte, ones before.
  logic [7:0]  miso_byte_a = 8'h00;
  bit          late_mode_a = 1'b0;
  logic        prev_sck_a = 1'b1, prev_csn_a = 1'b1, prev_rdy_a = 1'b0;
  int          falls_a = 0, rises_a = 0, low_run_a = 0, high_run_a = 0;
  int          csn_low_last_a = 0, gap_last_a = 0, rsp_cnt_a = 0, rdy_rise_a = 0;
  int          pend_a = 0, idx_a = 0;
  logic        pend_bit_a = 1'b0, mbit_a = 1'b0;
  logic [23:0] mosi_sh_a = '0;

  always @(negedge clk) begin
    if (!prev_sck_a && sck_a) begin
      rises_a++;
      mosi_sh_a = {mosi_sh_a[22:0], mosi_a};
    end
    if (pend_a > 0) begin
      pend_a--;
      if (pend_a == 0) miso_a = pend_bit_a;
    end
    if (csn_a) begin
      falls_a = 0;
    end else if (prev_sck_a && !sck_a) begin
      idx_a  = 23 - falls_a;
      falls_a++;
      mbit_a = (idx_a < 8) ? miso_byte_a[idx_a] : 1'b1;
      if (late_mode_a) begin
        pend_a     = CLK_DIV_A + 1;
        pend_bit_a = mbit_a;
      end else begin
        miso_a = mbit_a;
      end
    end
    if (csn_a) begin
      if (!prev_csn_a) csn_low_last_a = low_run_a;
      low_run_a = 0;
      high_run_a++;
    end else begin
      if (prev_csn_a) gap_last_a = high_run_a;
      high_run_a = 0;
      low_run_a++;
    end
    if (rsp_a) rsp_cnt_a++;
    if (ready_a && !prev_rdy_a) rdy_rise_a = cyc;
    prev_sck_a = sck_a;
    prev_csn_a = csn_a;
    prev_rdy_a = ready_a;
  end

  // Peripheral model B plus SCK period tracking.
  logic [7:0]  miso_byte_b = 8'h00;
  logic        prev_sck_b = 1'b1, prev_csn_b = 1'b1;
  int          falls_b = 0, rises_b = 0, idx_b = 0, last_rise_b = -1;
  int          pmin_b = 1000, pmax_b = 0, pmin_last_b = 0, pmax_last_b = 0;
  logic [23:0] mosi_sh_b = '0;

  always @(negedge clk) begin
    if (!prev_sck_b && sck_b) begin
      rises_b++;
      mosi_sh_b = {mosi_sh_b[22:0], mosi_b};
      if (last_rise_b >= 0) begin
        if (cyc - last_rise_b < pmin_b) pmin_b = cyc - last_rise_b;
        if (cyc - last_rise_b > pmax_b) pmax_b = cyc - last_rise_b;
      end
      last_rise_b = cyc;
    end
    if (csn_b) begin
      if (!prev_csn_b) begin
        pmin_last_b = pmin_b;
        pmax_last_b = pmax_b;
      end
      falls_b     = 0;
      last_rise_b = -1;
      pmin_b      = 1000;
      pmax_b      = 0;
    end else if (prev_sck_b && !sck_b) begin
      idx_b  = 23 - falls_b;
      falls_b++;
      miso_b = (idx_b < 8) ? miso_byte_b[idx_b] : 1'b1;
    end
    prev_sck_b = sck_b;
    prev_csn_b = csn_b;
  end

  task automatic send_a(input logic w, input logic [7:0] ad, input logic [7:0] wd,
                        output int t_acc, output bit ok);
    ok = 1'b0; t_acc = 0;
    @(posedge clk); #1;
    valid_a = 1'b1; wr_a = w; addr_a = ad; wdata_a = wd;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (ready_a) begin t_acc = cyc; ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    valid_a = 1'b0; wr_a = 1'b0; addr_a = 8'h00; wdata_a = 8'h00;
  endtask

  task automatic wait_rsp_a(output int t_rsp, output logic [7:0] d, output bit ok);
    ok = 1'b0; t_rsp = 0; d = 8'h00;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (rsp_a) begin t_rsp = cyc; d = rdata_a; ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (csn_a !== 1'b1)     begin bad++; $display("FAIL rst_csn: got %b required 1", csn_a); end
    total++; if (sck_a !== 1'b1)     begin bad++; $display("FAIL rst_sck: got %b required 1", sck_a); end
    total++; if (mosi_a !== 1'b0)    begin bad++; $display("FAIL rst_mosi: got %b required 0", mosi_a); end
    total++; if (rsp_a !== 1'b0)     begin bad++; $display("FAIL rst_rsp_valid: got %b required 0", rsp_a); end
    total++; if (rdata_a !== 8'h00)  begin bad++; $display("FAIL rst_rdata: got %h required 00", rdata_a); end
    total++; if (ready_a !== 1'b0)   begin bad++; $display("FAIL rst_ready_in_reset: got %b required 0", ready_a); end
    @(posedge clk); #1;
    srst_a = 1'b0; srst_b = 1'b0;
    @(negedge clk);
    total++; if (ready_a !== 1'b1)   begin bad++; $display("FAIL rst_ready_after_release: got %b required 1", ready_a); end
    total++; if (ready_b !== 1'b1)   begin bad++; $display("FAIL rst_ready_b_after_release: got %b required 1", ready_b); end
  endtask

  task automatic test_write();
    int t, tr, r0; logic [7:0] d; bit ok;
    r0 = rises_a;
    send_a(1'b1, 8'h10, 8'hA5, t, ok);
    total++; if (!ok) begin bad++; $display("FAIL wr_accept: got %0d required 1", ok); end
    wait_rsp_a(tr, d, ok);
    total++; if (!ok || tr - t != 197) begin bad++; $display("FAIL wr_rsp_time: got %0d required 197", tr - t); end
    total++; if (d !== 8'h00) begin bad++; $display("FAIL wr_rdata: got %h required 00", d); end
    repeat (5) @(negedge clk);
    total++; if (mosi_sh_a !== 24'h0210A5) begin bad++; $display("FAIL wr_mosi_frame: got %h required 0210a5", mosi_sh_a); end
    total++; if (rises_a - r0 != 24) begin bad++; $display("FAIL wr_sck_rises: got %0d required 24", rises_a - r0); end
    total++; if (rdy_rise_a - t != 199) begin bad++; $display("FAIL wr_ready_return: got %0d required 199", rdy_rise_a - t); end
    total++; if (csn_low_last_a != 196) begin bad++; $display("FAIL wr_csn_low: got %0d required 196", csn_low_last_a); end
  endtask

  task automatic test_read();
    int t, tr; logic [7:0] d; bit ok;
    miso_byte_a = 8'h5C;
    send_a(1'b0, 8'h20, 8'h77, t, ok);
    wait_rsp_a(tr, d, ok);
    total++; if (!ok || tr - t != 197) begin bad++; $display("FAIL rd_rsp_time: got %0d required 197", tr - t); end
    total++; if (d !== 8'h5C) begin bad++; $display("FAIL rd_rdata: got %h required 5c", d); end
    repeat (5) @(negedge clk);
    total++; if (mosi_sh_a !== 24'h032000) begin bad++; $display("FAIL rd_mosi_frame: got %h required 032000", mosi_sh_a); end
    total++; if (csn_low_last_a != 196) begin bad++; $display("FAIL rd_csn_low: got %0d required 196", csn_low_last_a); end
  endtask

  task automatic test_back_to_back();
    int t1, t2, tr2, n_rsp; logic [7:0] d1, d2; bit ok, got1, got2;
    miso_byte_a = 8'h96;
    t1 = 0; t2 = 0; n_rsp = 0; d1 = 8'hFF; got1 = 1'b0; got2 = 1'b0;
    @(posedge clk); #1;
    valid_a = 1'b1; wr_a = 1'b1; addr_a = 8'h3C; wdata_a = 8'h81;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (ready_a) begin t1 = cyc; got1 = 1'b1; break; end
    end
    @(posedge clk); #1;
    wr_a = 1'b0; addr_a = 8'h33; wdata_a = 8'hFF;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (rsp_a) begin n_rsp++; d1 = rdata_a; end
      if (ready_a) begin t2 = cyc; got2 = 1'b1; break; end
    end
    @(posedge clk); #1;
    valid_a = 1'b0; addr_a = 8'h00; wdata_a = 8'h00;
    total++; if (!got1 || !got2 || t2 - t1 != 199) begin bad++; $display("FAIL b2b_second_accept: got %0d required 199", t2 - t1); end
    total++; if (n_rsp != 1 || d1 !== 8'h00) begin bad++; $display("FAIL b2b_first_rsp: got count %0d data %h required count 1 data 00", n_rsp, d1); end
    wait_rsp_a(tr2, d2, ok);
    total++; if (!ok || tr2 - t2 != 197) begin bad++; $display("FAIL b2b_second_rsp_time: got %0d required 197", tr2 - t2); end
    total++; if (d2 !== 8'h96) begin bad++; $display("FAIL b2b_second_rdata: got %h required 96", d2); end
    repeat (5) @(negedge clk);
    total++; if (gap_last_a < 2) begin bad++; $display("FAIL b2b_csn_gap: got %0d required >=2", gap_last_a); end
    total++; if (mosi_sh_a !== 24'h033300) begin bad++; $display("FAIL b2b_second_frame: got %h required 033300", mosi_sh_a); end
  endtask

  task automatic test_reset_mid();
    int t, tr, r0; logic [7:0] d; bit ok, saw_rsp;
    r0 = rsp_cnt_a; saw_rsp = 1'b0;
    send_a(1'b1, 8'h5E, 8'h3C, t, ok);
    repeat (108) @(posedge clk);
    #1 srst_a = 1'b1;
    @(negedge clk);
    total++; if (csn_a !== 1'b0 || mosi_a !== 1'b1) begin bad++; $display("FAIL mid_frame_active: got csn %b mosi %b required 0 1", csn_a, mosi_a); end
    @(negedge clk);
    total++; if (csn_a !== 1'b1 || sck_a !== 1'b1 || mosi_a !== 1'b0) begin bad++; $display("FAIL mid_rst_outputs: got csn %b sck %b mosi %b required 1 1 0", csn_a, sck_a, mosi_a); end
    total++; if (ready_a !== 1'b0) begin bad++; $display("FAIL mid_rst_ready_in_reset: got %b required 0", ready_a); end
    @(posedge clk); #1 srst_a = 1'b0;
    @(negedge clk);
    total++; if (ready_a !== 1'b1) begin bad++; $display("FAIL mid_rst_ready_release: got %b required 1", ready_a); end
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (rsp_a) saw_rsp = 1'b1;
    end
    total++; if (saw_rsp || rsp_cnt_a != r0) begin bad++; $display("FAIL mid_rst_no_rsp: got %0d responses required 0", rsp_cnt_a - r0); end
    miso_byte_a = 8'hE7;
    send_a(1'b0, 8'h44, 8'h00, t, ok);
    wait_rsp_a(tr, d, ok);
    total++; if (!ok || tr - t != 197 || d !== 8'hE7) begin bad++; $display("FAIL mid_rst_followup_read: got time %0d data %h required 197 e7", tr - t, d); end
  endtask

  task automatic test_fast();
    int t, tr, r0; logic [7:0] d; bit ok;
    miso_byte_b = 8'h3A; r0 = rises_b; ok = 1'b0; t = 0; tr = 0; d = 8'h00;
    @(posedge clk); #1;
    valid_b = 1'b1; wr_b = 1'b0; addr_b = 8'h7E; wdata_b = 8'h11;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (ready_b) begin t = cyc; ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    valid_b = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL fast_accept: got %0d required 1", ok); end
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rsp_b) begin tr = cyc; d = rdata_b; ok = 1'b1; break; end
    end
    total++; if (!ok || tr - t != 99) begin bad++; $display("FAIL fast_rsp_time: got %0d required 99", tr - t); end
    total++; if (d !== 8'h3A) begin bad++; $display("FAIL fast_rdata: got %h required 3a", d); end
    repeat (5) @(negedge clk);
    total++; if (pmin_last_b != 4 || pmax_last_b != 4) begin bad++; $display("FAIL fast_sck_period: got min %0d max %0d required 4 4", pmin_last_b, pmax_last_b); end
    total++; if (mosi_sh_b !== 24'h037E00 || rises_b - r0 != 24) begin bad++; $display("FAIL fast_frame: got %h rises %0d required 037e00 24", mosi_sh_b, rises_b - r0); end
  endtask

`ifdef CLNX_SPI_LATE_SAMPLE_EN
  task automatic test_late_sample();
    int t, tr; logic [7:0] d; bit ok;
    late_mode_a = 1'b1;
    miso_byte_a = 8'hC3;
    send_a(1'b0, 8'h55, 8'h00, t, ok);
    wait_rsp_a(tr, d, ok);
    total++; if (!ok || d !== 8'hC3) begin bad++; $display("FAIL late_rdata: got %h required c3", d); end
    repeat (5) @(negedge clk);
    late_mode_a = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid();
    test_fast();
`ifdef CLNX_SPI_LATE_SAMPLE_EN
    test_late_sample();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clnx_spi_ctrl_master.md
# clnx_spi_ctrl_master

SPI controller (initiator) on the CPNX100 sensor-bridge side that issues single-byte register read/write transactions to the CrossLink-NX companion FPGA's SPI peripheral control interface. It accepts requests on a valid/ready port, serialises a 24-bit mode-3 SPI frame on CSN/SCK/MOSI, captures MISO, and returns one response per request. It is the initiator end of the CTRL_SPI link: MIPI enable, soft reset, debug, LMMI and flash-forward registers are all reached through it.

## Interface
- CLK_DIV, 4: SCK half-period in i_clk cycles; minimum 2.
- CS_SETUP, 2: i_clk cycles CSN is low before the first SCK falling edge; minimum 1.
- CS_HOLD, 2: i_clk cycles after the last SCK rising half-period before CSN rises; also the minimum CSN-high gap between frames; minimum 1.
- i_clk  in  1  single clock for all logic.
- i_srst  in  1  synchronous active-high reset.
- i_req_valid  in  1  request valid.
- o_req_ready  out  1  request ready; high only in IDLE.
- i_req_wr  in  1  1 = write, 0 = read.
- i_req_addr  in  8  register address.
- i_req_wdata  in  8  write data; ignored on reads.
- o_rsp_valid  out  1  one-cycle response pulse, once per accepted request.
- o_rsp_rdata  out  8  captured read byte; 0x00 for writes.
- o_spi_csn  out  1  chip select, active low.
- o_spi_sck  out  1  SPI clock, idles high.
- o_spi_mosi  out  1  controller data out.
- i_spi_miso  in  1  peripheral data in; synchronised internally with 2 flops.

## Operation
- The frame is 24 bits, MSB first: opcode byte (0x02 write, 0x03 read), address byte, then data byte. In a write frame, MOSI carries the data byte. In a read frame, MOSI is 0x00 and the peripheral returns the data on MISO during the third byte.
- The FSM has five states: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE: the request is accepted on i_req_valid && o_req_ready, and all request fields are latched into a 24-bit shift register.
- SETUP: CSN is 0, SCK is 1, and MOSI drives bit 23. The FSM stays here for CS_SETUP cycles.
- SHIFT: each bit is a low phase of CLK_DIV cycles followed by a high phase of CLK_DIV cycles. MOSI updates on the cycle SCK falls, except for bit 23, which was already driven in SETUP. MISO is sampled on the cycle SCK rises. The FSM leaves after the high phase of bit 0.
- HOLD: SCK is 1 and CSN is 0 for CS_HOLD cycles.
- GAP: entry cycle sets CSN=1 and pulses o_rsp_valid. The FSM stays in GAP for CS_HOLD cycles.
- o_rsp_rdata holds its value until the next response. There is no response backpressure.
- Reset values: o_spi_csn=1, o_spi_sck=1, o_spi_mosi=0, o_rsp_valid=0, o_rsp_rdata=0x00.
  - o_req_ready=0 while i_srst is high.
  - o_req_ready=1 from the first cycle after i_srst is released.
- Reset mid-frame: on the next cycle, outputs take their reset values and the FSM returns to IDLE. No response is issued and the request is dropped.
- If i_req_valid is held high while the block is busy, the request is not lost; it is accepted when the FSM returns to IDLE.

## Timing
- Let T be the accept cycle.
- CSN falls at T+1.
- The first SCK fall is at T+1+CS_SETUP.
- o_rsp_valid pulses at T+1+CS_SETUP+48·CLK_DIV+CS_HOLD, which is T+197 with the defaults.
- o_req_ready returns CS_HOLD cycles later: T+199 with the defaults.
- SCK frequency = f(i_clk) / (2·CLK_DIV).
- The peripheral synchronises its inputs at 60 MHz. CLK_DIV must keep each SCK phase at least 3 peripheral cycles long.

## Configuration
- CLNX_SPI_LATE_SAMPLE_EN:
  - When defined, MISO is sampled on the last cycle of each high phase, CLK_DIV−1 cycles after the rise. This absorbs the peripheral's input-synchroniser and output-register latency.
  - When undefined, MISO is sampled on the rising-edge cycle.
  - The macro affects nothing else.

## Structure
- Package clnx_spi_pkg holds:
  - OP_WR=8'h02 and OP_RD=8'h03
  - FRAME_BITS=24
  - the FSM state enum.
- Sub-module clnx_spi_sck_gen holds the CLK_DIV phase counter. It produces SCK plus one-cycle fall, rise and late-sample strobes, and counts the 24 bits.

## Test plan
- Write, addr 0x10, data 0xA5, defaults → MOSI frame 0x0210A5, 24 SCK rising edges, o_rsp_valid at T+197 with o_rsp_rdata=0x00, o_req_ready at T+199.
- Read, addr 0x20, MISO model returns 0x5C → MOSI 0x032000, o_rsp_rdata=0x5C, CSN low exactly 196 cycles.
- Two back-to-back requests with i_req_valid held → second accepted at T+199, CSN high ≥2 cycles between frames, two response pulses.
- i_srst pulsed during bit 10 → next cycle CSN=1, SCK=1, MOSI=0, o_rsp_valid never pulses, o_req_ready=1 after release; a following read returns correct data.
- CLK_DIV=2, CS_SETUP=1, CS_HOLD=1, read → response at T+99, SCK period 4 cycles.
- With CLNX_SPI_LATE_SAMPLE_EN, MISO model updates CLK_DIV+1 cycles after each SCK fall, returning 0xC3 → o_rsp_rdata=0xC3. Run this case only with the macro defined.
